// File: rtl/qbert_pkg.sv
// Shared types and helpers for the Q*bert jump controller.
package qbert_pkg;

    // Jump command codes as seen by the sprite layer.
    typedef enum logic [2:0] {
        NONE = 3'b000,
        DR   = 3'b001,
        DL   = 3'b010,
        UR   = 3'b011,
        UL   = 3'b100
    } jump_dir_t;

    // Controller states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READY  = 3'd1,
        LAUNCH = 3'd2,
        MOVE   = 3'd3,
        FALL   = 3'd4,
        OVER   = 3'd5
    } ctrl_state_t;

    // Index of the first cube in row r, r*(r+1)/2, as a sum of small terms.
    // Only ever evaluated on constants to build a lookup table.
    function automatic int row_base(input int r);
        int acc;
        acc = 0;
        for (int i = 1; i <= r; i++) acc += i;
        return acc;
    endfunction

endpackage

// File: rtl/qbert_pyramid_nav.sv
// Pyramid navigation: from the current cube and a direction, produce the
// target row/col, its linear index and whether the jump leaves the pyramid.
// A bad jump reports the current cube as the target.
module qbert_pyramid_nav
    import qbert_pkg::*;
#(
    parameter int N_ROW  = 7,
    parameter int N_CUBE = 28,
    parameter int RW     = $clog2(N_ROW + 1),
    parameter int IW     = $clog2(N_CUBE)
) (
    input  logic [RW-1:0] row,
    input  logic [RW-1:0] col,
    input  jump_dir_t     dir,
    output logic [RW-1:0] next_row,
    output logic [RW-1:0] next_col,
    output logic [IW-1:0] next_index,
    output logic          bad
);

    // Constant table of row start indices, so no multiplier is needed.
    logic [IW-1:0] base_lut [2**RW];

    for (genvar g = 0; g < 2**RW; g++) begin : g_base
        assign base_lut[g] = IW'(row_base(g));
    end

    // Apply the move, or stay put when the move falls off an edge.
    always_comb begin
        next_row = row;
        next_col = col;
        bad      = 1'b0;
        case (dir)
            DR: begin
                if (row == RW'(N_ROW - 1)) bad = 1'b1;
                else begin
                    next_row = row + RW'(1);
                    next_col = col + RW'(1);
                end
            end
            DL: begin
                if (row == RW'(N_ROW - 1)) bad = 1'b1;
                else next_row = row + RW'(1);
            end
            UR: begin
                if (col == row) bad = 1'b1;
                else next_row = row - RW'(1);
            end
            UL: begin
                if (col == '0) bad = 1'b1;
                else begin
                    next_row = row - RW'(1);
                    next_col = col - RW'(1);
                end
            end
            default: ;
        endcase
        next_index = base_lut[next_row] + IW'(next_col);
    end

endmodule

// File: rtl/qbert_jump_ctrl.sv
// Q*bert jump controller: turns button edges into jump commands, tracks the
// current cube, the visited bitmap and the lives counter.
//
// Sprite handshake: a command (e_jump_qb/e_next_qb/e_bad_jump) is raised in
// LAUNCH and held unchanged until the sprite layer has taken it (done_move
// drops to 0) and then finished it (done_move returns to 1); the command is
// retired on the cycle that rising edge is seen.
module qbert_jump_ctrl
    import qbert_pkg::*;
#(
    parameter int N_ROW       = 7,
    parameter int N_cube      = 28,
    parameter int RESPAWN_CYC = 50_000_000,
    parameter int N_LIVES     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        btn_dir,
    input  logic              done_move,
    output logic              e_start_qb,
    output logic [2:0]        e_jump_qb,
    output logic              e_bad_jump,
    output logic [N_cube-1:0] position_qb,
    output logic [N_cube-1:0] e_next_qb,
    output logic [N_cube-1:0] cube_visited,
    output logic              all_visited,
    output logic [1:0]        lives,
    output logic              game_over,
    output logic [2:0]        state_dbg
);

    localparam int RW = $clog2(N_ROW + 1);
    localparam int IW = $clog2(N_cube);
    localparam int CW = $clog2(RESPAWN_CYC + 1);

    ctrl_state_t   state, state_n;
    logic [3:0]    btn_r, btn_p;
    logic          start_r, start_p, done_r, done_p;
    logic [RW-1:0] row, col, tgt_row, tgt_col;
    logic [RW-1:0] nav_row, nav_col;
    logic [IW-1:0] nav_idx;
    logic          nav_bad;
    logic [CW-1:0] fall_cnt;
    jump_dir_t     req_dir;
    logic          do_start, do_launch, move_end, land_good;
    logic          fall_done, respawn, lose_last;

    wire [3:0] btn_edge   = btn_r & ~btn_p;
    wire       start_rise = start_r & ~start_p;
    wire       done_rise  = done_r & ~done_p;

    assign all_visited = &cube_visited;
    assign state_dbg   = state;

    // Register the asynchronous-ish inputs once and keep a delayed copy for edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_r   <= '0;
            btn_p   <= '0;
            start_r <= 1'b0;
            start_p <= 1'b0;
            done_r  <= 1'b0;
            done_p  <= 1'b0;
        end else begin
            btn_r   <= btn_dir;
            btn_p   <= btn_r;
            start_r <= start;
            start_p <= start_r;
            done_r  <= done_move;
            done_p  <= done_r;
        end
    end

    // Resolve simultaneous button edges: DR > DL > UR > UL.
    always_comb begin
        req_dir = NONE;
        if (btn_edge[0])      req_dir = DR;
        else if (btn_edge[1]) req_dir = DL;
        else if (btn_edge[2]) req_dir = UR;
        else if (btn_edge[3]) req_dir = UL;
    end

    qbert_pyramid_nav #(
        .N_ROW  (N_ROW),
        .N_CUBE (N_cube),
        .RW     (RW),
        .IW     (IW)
    ) u_nav (
        .row        (row),
        .col        (col),
        .dir        (req_dir),
        .next_row   (nav_row),
        .next_col   (nav_col),
        .next_index (nav_idx),
        .bad        (nav_bad)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state logic and one-cycle datapath strobes.
    always_comb begin
        state_n   = state;
        do_start  = 1'b0;
        do_launch = 1'b0;
        move_end  = 1'b0;
        land_good = 1'b0;
        fall_done = 1'b0;
        respawn   = 1'b0;
        lose_last = 1'b0;
        case (state)
            IDLE, OVER: begin
                if (start_rise) begin
                    do_start = 1'b1;
                    state_n  = READY;
                end
            end
            READY: begin
                if (req_dir != NONE) begin
                    do_launch = 1'b1;
                    state_n   = LAUNCH;
                end
            end
            LAUNCH: begin
                if (!done_r) state_n = MOVE;
            end
            MOVE: begin
                if (done_rise) begin
                    move_end = 1'b1;
                    if (e_bad_jump) state_n = FALL;
                    else begin
                        land_good = 1'b1;
                        state_n   = READY;
                    end
                end
            end
            FALL: begin
                if (fall_cnt == CW'(RESPAWN_CYC - 1)) begin
                    fall_done = 1'b1;
                    if (lives <= 2'd1) begin
                        lose_last = 1'b1;
                        state_n   = OVER;
                    end else begin
                        respawn = 1'b1;
                        state_n = READY;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Game datapath: command latch, position, visited map, lives, respawn timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_start_qb   <= 1'b0;
            e_jump_qb    <= NONE;
            e_bad_jump   <= 1'b0;
            position_qb  <= N_cube'(1);
            e_next_qb    <= N_cube'(1);
            cube_visited <= '0;
            lives        <= '0;
            game_over    <= 1'b0;
            row          <= '0;
            col          <= '0;
            tgt_row      <= '0;
            tgt_col      <= '0;
            fall_cnt     <= '0;
        end else begin
            e_start_qb <= do_start | respawn;
            fall_cnt   <= (state == FALL) ? fall_cnt + CW'(1) : '0;
            if (do_start) begin
                lives        <= 2'(N_LIVES);
                cube_visited <= N_cube'(1);
                position_qb  <= N_cube'(1);
                e_next_qb    <= N_cube'(1);
                row          <= '0;
                col          <= '0;
                e_jump_qb    <= NONE;
                e_bad_jump   <= 1'b0;
                game_over    <= 1'b0;
            end
            if (do_launch) begin
                e_jump_qb  <= req_dir;
                e_next_qb  <= N_cube'(1) << nav_idx;
                e_bad_jump <= nav_bad;
                tgt_row    <= nav_row;
                tgt_col    <= nav_col;
            end
            if (move_end) e_jump_qb <= NONE;
            if (land_good) begin
                position_qb  <= e_next_qb;
                cube_visited <= cube_visited | e_next_qb;
                row          <= tgt_row;
                col          <= tgt_col;
            end
            if (fall_done) lives <= lives - 2'd1;
            if (lose_last) game_over <= 1'b1;
            if (respawn) begin
                row         <= '0;
                col         <= '0;
                position_qb <= N_cube'(1);
                e_next_qb   <= N_cube'(1);
                e_bad_jump  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_qbert_jump_ctrl.sv
// Directed bench for qbert_jump_ctrl with a small sprite-layer model.
module tb_qbert_jump_ctrl;
    import qbert_pkg::*;

    localparam int NC   = 28;
    localparam int RESP = 20;

    logic          clk = 1'b0;
    logic          reset, start, done_move;
    logic [3:0]    btn_dir;
    logic          e_start_qb, e_bad_jump, all_visited, game_over;
    logic [2:0]    e_jump_qb, state_dbg;
    logic [NC-1:0] position_qb, e_next_qb, cube_visited;
    logic [1:0]    lives;

    int errors = 0;
    int checks = 0;

    qbert_jump_ctrl #(
        .N_ROW       (7),
        .N_cube      (NC),
        .RESPAWN_CYC (RESP),
        .N_LIVES     (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .btn_dir      (btn_dir),
        .done_move    (done_move),
        .e_start_qb   (e_start_qb),
        .e_jump_qb    (e_jump_qb),
        .e_bad_jump   (e_bad_jump),
        .position_qb  (position_qb),
        .e_next_qb    (e_next_qb),
        .cube_visited (cube_visited),
        .all_visited  (all_visited),
        .lives        (lives),
        .game_over    (game_over),
        .state_dbg    (state_dbg)
    );

    // Clock; inputs change and outputs are sampled on the falling edge.
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Raise start and wait for the start pulse.
    task automatic do_start_game(output bit ok);
        int k;
        start = 1'b1;
        k = 0;
        while (e_start_qb !== 1'b1 && k < 8) begin
            @(negedge clk);
            k++;
        end
        ok = (e_start_qb === 1'b1);
        start = 1'b0;
    endtask

    // Press a button, capture the command, play the sprite layer
    // (drop done_move after lo cycles, raise it after hi more), optionally
    // press mid_b while moving, and wait for the command to retire.
    task automatic do_jump(input logic [3:0] b, input logic [3:0] mid_b,
                           input int lo, input int hi,
                           output logic [2:0] jd, output logic bad,
                           output logic [NC-1:0] nx, output bit held, output bit ok);
        int k;
        ok = 1'b1;
        held = 1'b1;
        jd = 3'b000;
        bad = 1'b0;
        nx = '0;
        btn_dir = b;
        k = 0;
        while (e_jump_qb === 3'b000 && k < 6) begin
            @(negedge clk);
            k++;
        end
        if (e_jump_qb === 3'b000) begin
            ok = 1'b0;
            btn_dir = 4'b0000;
            return;
        end
        jd = e_jump_qb;
        bad = e_bad_jump;
        nx = e_next_qb;
        btn_dir = 4'b0000;
        for (int i = 0; i < lo; i++) begin
            @(negedge clk);
            if (e_jump_qb !== jd || e_next_qb !== nx || e_bad_jump !== bad) held = 1'b0;
        end
        done_move = 1'b0;
        for (int i = 0; i < hi; i++) begin
            @(negedge clk);
            if (e_jump_qb !== jd || e_next_qb !== nx || e_bad_jump !== bad) held = 1'b0;
            if (i == 2) btn_dir = mid_b;
            if (i == 4) btn_dir = 4'b0000;
        end
        done_move = 1'b1;
        k = 0;
        while (e_jump_qb !== 3'b000 && k < 6) begin
            @(negedge clk);
            k++;
        end
        if (e_jump_qb !== 3'b000) ok = 1'b0;
    endtask

    task automatic wait_start_pulse(output bit ok, output int cyc);
        cyc = 0;
        while (e_start_qb !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        ok = (e_start_qb === 1'b1);
    endtask

    task automatic wait_game_over(output bit ok);
        int k;
        k = 0;
        while (game_over !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        ok = (game_over === 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        btn_dir = 4'b0000;
        done_move = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        checks++; if (position_qb !== 28'h1) begin errors++; $display("FAIL reset_position got=%h exp=%h", position_qb, 28'h1); end
        checks++; if (e_next_qb !== 28'h1) begin errors++; $display("FAIL reset_next got=%h exp=%h", e_next_qb, 28'h1); end
        checks++; if (cube_visited !== 28'h0) begin errors++; $display("FAIL reset_visited got=%h exp=0", cube_visited); end
        checks++; if ({e_start_qb, e_jump_qb, e_bad_jump, all_visited, lives, game_over} !== 9'd0) begin
            errors++; $display("FAIL reset_outputs got start=%b jump=%b bad=%b allv=%b lives=%0d go=%b exp all 0",
                               e_start_qb, e_jump_qb, e_bad_jump, all_visited, lives, game_over);
        end
        checks++; if (state_dbg !== 3'(IDLE)) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, 3'(IDLE)); end
    endtask

    task automatic test_start();
        bit ok;
        do_start_game(ok);
        checks++; if (!ok) begin errors++; $display("FAIL start_pulse got=0 exp=1"); end
        checks++; if (lives !== 2'd3) begin errors++; $display("FAIL start_lives got=%0d exp=3", lives); end
        checks++; if (position_qb !== 28'h1) begin errors++; $display("FAIL start_position got=%h exp=1", position_qb); end
        checks++; if (cube_visited !== 28'h1) begin errors++; $display("FAIL start_visited got=%h exp=1", cube_visited); end
        checks++; if (state_dbg !== 3'(READY)) begin errors++; $display("FAIL start_state got=%0d exp=%0d", state_dbg, 3'(READY)); end
        tick(1);
        checks++; if (e_start_qb !== 1'b0) begin errors++; $display("FAIL start_pulse_width got=%b exp=0", e_start_qb); end
    endtask

    task automatic test_jump_dr();
        logic [2:0] jd; logic bad; logic [NC-1:0] nx; bit held, ok;
        do_jump(4'b0001, 4'b0000, 5, 40, jd, bad, nx, held, ok);
        checks++; if (!ok) begin errors++; $display("FAIL dr_handshake got=timeout exp=done"); end
        checks++; if (jd !== 3'b001) begin errors++; $display("FAIL dr_dir got=%b exp=001", jd); end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL dr_bad got=%b exp=0", bad); end
        checks++; if (nx !== 28'h4) begin errors++; $display("FAIL dr_next got=%h exp=4", nx); end
        checks++; if (!held) begin errors++; $display("FAIL dr_held got=changed exp=stable"); end
        checks++; if (position_qb !== 28'h4) begin errors++; $display("FAIL dr_position got=%h exp=4", position_qb); end
        checks++; if (cube_visited !== 28'h5) begin errors++; $display("FAIL dr_visited got=%h exp=5", cube_visited); end
        checks++; if (state_dbg !== 3'(READY)) begin errors++; $display("FAIL dr_state got=%0d exp=%0d", state_dbg, 3'(READY)); end
        // Back up to the apex with a legal UL.
        do_jump(4'b1000, 4'b0000, 3, 10, jd, bad, nx, held, ok);
        checks++; if (!ok || jd !== 3'b100 || bad !== 1'b0) begin errors++; $display("FAIL ul_cmd got=ok%0d dir%b bad%b exp=ok1 dir100 bad0", ok, jd, bad); end
        checks++; if (position_qb !== 28'h1) begin errors++; $display("FAIL ul_position got=%h exp=1", position_qb); end
        checks++; if (cube_visited !== 28'h5) begin errors++; $display("FAIL ul_visited got=%h exp=5", cube_visited); end
    endtask

    task automatic test_bad_jump();
        logic [2:0] jd; logic bad; logic [NC-1:0] nx; bit held, ok; int cyc;
        do_jump(4'b1000, 4'b0000, 5, 20, jd, bad, nx, held, ok);
        checks++; if (!ok || jd !== 3'b100) begin errors++; $display("FAIL bad_cmd got=ok%0d dir%b exp=ok1 dir100", ok, jd); end
        checks++; if (bad !== 1'b1) begin errors++; $display("FAIL bad_flag got=%b exp=1", bad); end
        checks++; if (nx !== 28'h1) begin errors++; $display("FAIL bad_next got=%h exp=1", nx); end
        checks++; if (state_dbg !== 3'(FALL)) begin errors++; $display("FAIL bad_state got=%0d exp=%0d", state_dbg, 3'(FALL)); end
        wait_start_pulse(ok, cyc);
        checks++; if (!ok || cyc != RESP) begin errors++; $display("FAIL fall_length got=%0d exp=%0d", cyc, RESP); end
        checks++; if (lives !== 2'd2) begin errors++; $display("FAIL fall_lives got=%0d exp=2", lives); end
        checks++; if (position_qb !== 28'h1 || e_next_qb !== 28'h1) begin errors++; $display("FAIL respawn_pos got=%h/%h exp=1/1", position_qb, e_next_qb); end
        checks++; if (state_dbg !== 3'(READY) || game_over !== 1'b0) begin errors++; $display("FAIL respawn_state got=%0d go=%b exp=%0d go=0", state_dbg, game_over, 3'(READY)); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] jd; logic bad; logic [NC-1:0] nx; bit held, ok, extra;
        // DR and UL together, then UL pressed mid-move (legal from the landing cube if it leaked).
        do_jump(4'b1001, 4'b1000, 4, 15, jd, bad, nx, held, ok);
        checks++; if (!ok || jd !== 3'b001 || nx !== 28'h4) begin errors++; $display("FAIL prio_cmd got=ok%0d dir%b next%h exp=ok1 dir001 next4", ok, jd, nx); end
        extra = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (e_jump_qb !== 3'b000) extra = 1'b1;
        end
        checks++; if (extra) begin errors++; $display("FAIL move_press_ignored got=jump exp=none"); end
        checks++; if (position_qb !== 28'h4 || state_dbg !== 3'(READY)) begin errors++; $display("FAIL prio_land got=%h st%0d exp=4 st%0d", position_qb, state_dbg, 3'(READY)); end
    endtask

    task automatic test_game_over();
        logic [2:0] jd; logic bad; logic [NC-1:0] nx; bit held, ok, seen; int cyc;
        // Start rise while playing is ignored.
        start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (e_start_qb === 1'b1) seen = 1'b1;
        end
        start = 1'b0;
        checks++; if (seen || lives !== 2'd2) begin errors++; $display("FAIL start_ignored got=pulse%0d lives%0d exp=pulse0 lives2", seen, lives); end
        // From (1,1): UR is off the edge.
        do_jump(4'b0100, 4'b0000, 2, 8, jd, bad, nx, held, ok);
        checks++; if (!ok || bad !== 1'b1 || nx !== 28'h4) begin errors++; $display("FAIL ur_edge got=ok%0d bad%b next%h exp=ok1 bad1 next4", ok, bad, nx); end
        wait_start_pulse(ok, cyc);
        checks++; if (!ok || lives !== 2'd1) begin errors++; $display("FAIL lives_to1 got=%0d exp=1", lives); end
        do_jump(4'b1000, 4'b0000, 2, 8, jd, bad, nx, held, ok);
        wait_game_over(ok);
        checks++; if (!ok || lives !== 2'd0) begin errors++; $display("FAIL over1 got=go%b lives%0d exp=go1 lives0", game_over, lives); end
        checks++; if (state_dbg !== 3'(OVER)) begin errors++; $display("FAIL over1_state got=%0d exp=%0d", state_dbg, 3'(OVER)); end
        btn_dir = 4'b0001;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (e_jump_qb !== 3'b000) seen = 1'b1;
        end
        btn_dir = 4'b0000;
        checks++; if (seen) begin errors++; $display("FAIL over_frozen got=jump exp=none"); end
        // Fresh game, then lose all three lives.
        do_start_game(ok);
        checks++; if (!ok || lives !== 2'd3 || game_over !== 1'b0 || cube_visited !== 28'h1) begin
            errors++; $display("FAIL restart got=lives%0d go%b vis%h exp=lives3 go0 vis1", lives, game_over, cube_visited);
        end
        do_jump(4'b0100, 4'b0000, 2, 8, jd, bad, nx, held, ok);
        wait_start_pulse(ok, cyc);
        checks++; if (!ok || lives !== 2'd2) begin errors++; $display("FAIL three_1 got=%0d exp=2", lives); end
        do_jump(4'b1000, 4'b0000, 2, 8, jd, bad, nx, held, ok);
        wait_start_pulse(ok, cyc);
        checks++; if (!ok || lives !== 2'd1) begin errors++; $display("FAIL three_2 got=%0d exp=1", lives); end
        do_jump(4'b0100, 4'b0000, 2, 8, jd, bad, nx, held, ok);
        wait_game_over(ok);
        checks++; if (!ok || lives !== 2'd0 || state_dbg !== 3'(OVER)) begin errors++; $display("FAIL three_3 got=lives%0d st%0d exp=lives0 st%0d", lives, state_dbg, 3'(OVER)); end
    endtask

    task automatic test_walk();
        logic [3:0] walk [42];
        logic [2:0] jd; logic bad; logic [NC-1:0] nx; bit held, ok, all_ok, any_bad;
        walk = '{4'h2, 4'h2, 4'h4, 4'h1, 4'h4, 4'h1, 4'h8, 4'h8,
                 4'h2, 4'h2, 4'h2, 4'h2, 4'h4, 4'h1, 4'h4, 4'h1, 4'h4, 4'h1, 4'h4, 4'h1,
                 4'h8, 4'h8, 4'h8, 4'h8, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2,
                 4'h4, 4'h1, 4'h4, 4'h1, 4'h4, 4'h1, 4'h4, 4'h1, 4'h4, 4'h1, 4'h4, 4'h1};
        do_start_game(ok);
        checks++; if (!ok || lives !== 2'd3 || game_over !== 1'b0) begin errors++; $display("FAIL restart2 got=lives%0d go%b exp=lives3 go0", lives, game_over); end
        all_ok = 1'b1;
        any_bad = 1'b0;
        for (int m = 0; m < 42; m++) begin
            if (m == 41) begin
                checks++; if (all_visited !== 1'b0) begin errors++; $display("FAIL walk_allv_early got=%b exp=0", all_visited); end
            end
            do_jump(walk[m], 4'b0000, 1, 6, jd, bad, nx, held, ok);
            if (!ok) all_ok = 1'b0;
            if (bad) any_bad = 1'b1;
        end
        checks++; if (!all_ok || any_bad) begin errors++; $display("FAIL walk_moves got=ok%0d bad%0d exp=ok1 bad0", all_ok, any_bad); end
        checks++; if (all_visited !== 1'b1 || cube_visited !== 28'hFFFFFFF) begin errors++; $display("FAIL walk_allv got=%b vis%h exp=1 visfffffff", all_visited, cube_visited); end
        checks++; if (position_qb !== 28'h8000000) begin errors++; $display("FAIL walk_end_pos got=%h exp=8000000", position_qb); end
    endtask

    task automatic test_reset_mid_move();
        int k;
        btn_dir = 4'b0001;
        k = 0;
        while (e_jump_qb === 3'b000 && k < 6) begin
            @(negedge clk);
            k++;
        end
        btn_dir = 4'b0000;
        done_move = 1'b0;
        tick(4);
        checks++; if (state_dbg !== 3'(MOVE)) begin errors++; $display("FAIL mid_state got=%0d exp=%0d", state_dbg, 3'(MOVE)); end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        done_move = 1'b1;
        checks++; if (e_jump_qb !== 3'b000 || position_qb !== 28'h1 || e_next_qb !== 28'h1 || lives !== 2'd0 || cube_visited !== 28'h0) begin
            errors++; $display("FAIL mid_reset got=jump%b pos%h next%h lives%0d vis%h exp=jump000 pos1 next1 lives0 vis0",
                               e_jump_qb, position_qb, e_next_qb, lives, cube_visited);
        end
        checks++; if (state_dbg !== 3'(IDLE)) begin errors++; $display("FAIL mid_reset_state got=%0d exp=%0d", state_dbg, 3'(IDLE)); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_jump_dr();
        test_bad_jump();
        test_back_to_back();
        test_game_over();
        test_walk();
        test_reset_mid_move();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
